// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and stall sequencing for the 5-stage MIPS pipeline.
// Covers load-use, branch-compare, mult/div busy and instruction-memory wait stalls.
module hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             MdStartD,
  input  logic             MdReadD,
  input  logic             ImemReadyF,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCount
);

  localparam int MDW = 6;
  localparam logic [MDW-1:0]   MD_LOAD  = MDW'(MD_LATENCY);
  localparam logic [MDW-1:0]   MD_ONE   = {{(MDW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    IWAIT = 1'b1
  } fetch_state_t;

  // $0 is hard-wired, so it can never carry a real dependency
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  logic           lwstall_s;
  logic           brstall_s;
  logic           mdstall_s;
  logic           dstall_s;
  logic           imiss_s;
  logic           md_busy_s;
  logic [MDW-1:0] md_cnt_r;
  logic [MDW-1:0] md_cnt_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] stall_cnt_nxt_s;
  fetch_state_t   state_r;
  fetch_state_t   state_nxt_s;

  assign md_busy_s  = (md_cnt_r != {MDW{1'b0}});
  assign MdBusy     = md_busy_s;
  assign StallCount = stall_cnt_r;

  // Execute-stage operand forwarding; the M stage is newer than W and wins
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && reg_match(WriteRegM, RsE)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && reg_match(WriteRegW, RsE)) begin
      ForwardAE = 2'b01;
    end else begin
      ForwardAE = 2'b00;
    end
    if (RegWriteM && reg_match(WriteRegM, RtE)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && reg_match(WriteRegW, RtE)) begin
      ForwardBE = 2'b01;
    end else begin
      ForwardBE = 2'b00;
    end
  end

  // Decode-stage branch-compare forwarding from ALUOutM
  always_comb begin
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAD = RegWriteM & reg_match(WriteRegM, RsD);
    ForwardBD = RegWriteM & reg_match(WriteRegM, RtD);
  end

  // Decode-stage stall sources
  always_comb begin
    lwstall_s = 1'b0;
    brstall_s = 1'b0;
    mdstall_s = 1'b0;
    lwstall_s = MemtoRegE & (reg_match(RtE, RsD) | reg_match(RtE, RtD));
    brstall_s = BranchD &
                ((RegWriteE & (reg_match(WriteRegE, RsD) | reg_match(WriteRegE, RtD))) |
                 (MemtoRegM & (reg_match(WriteRegM, RsD) | reg_match(WriteRegM, RtD))));
    mdstall_s = md_busy_s & (MdStartD | MdReadD);
  end

  assign dstall_s = lwstall_s | brstall_s | mdstall_s;
  assign imiss_s  = ~ImemReadyF;

  // Pipeline control; a Decode stall always beats a pending redirect or fetch bubble
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    StallF = dstall_s | imiss_s;
    StallD = dstall_s;
    FlushE = dstall_s;
    if (dstall_s) begin
      FlushD = 1'b0;
    end else begin
      FlushD = PCSrcD | imiss_s;
    end
  end

  // Mult/div busy counter next value; a fresh issue reloads over the decrement
  always_comb begin
    md_cnt_nxt_s = md_cnt_r;
    if (MdStartD && !dstall_s) begin
      md_cnt_nxt_s = MD_LOAD;
    end else if (md_busy_s) begin
      md_cnt_nxt_s = md_cnt_r - MD_ONE;
    end else begin
      md_cnt_nxt_s = md_cnt_r;
    end
  end

  // Saturating stall-cycle counter next value
  always_comb begin
    stall_cnt_nxt_s = stall_cnt_r;
    if (dstall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_nxt_s = stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_nxt_s = stall_cnt_r;
    end
  end

  // Fetch tracking FSM next state; outputs use ImemReadyF directly, not the state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (!ImemReadyF) begin
          state_nxt_s = IWAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      IWAIT: begin
        if (ImemReadyF) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IWAIT;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // State registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_r    <= {MDW{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
      state_r     <= RUN;
    end else begin
      md_cnt_r    <= md_cnt_nxt_s;
      stall_cnt_r <= stall_cnt_nxt_s;
      state_r     <= state_nxt_s;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations, a negedge monitor checks them.
module tb_hazard_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, PCSrcD, MdStartD, MdReadD, ImemReadyF;

  logic        StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MdBusy;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] StallCount;

  logic        s_StallF, s_StallD, s_FlushD, s_FlushE, s_ForwardAD, s_ForwardBD, s_MdBusy;
  logic [1:0]  s_ForwardAE, s_ForwardBE;
  logic [2:0]  s_StallCount;

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(32)) dut (
    .CLK(CLK), .rst_n(rst_n), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .PCSrcD(PCSrcD),
    .MdStartD(MdStartD), .MdReadD(MdReadD), .ImemReadyF(ImemReadyF),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MdBusy(MdBusy), .StallCount(StallCount)
  );

  // narrow counter instance so saturation is reachable in a short run
  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(3)) dut_s (
    .CLK(CLK), .rst_n(rst_n), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .PCSrcD(PCSrcD),
    .MdStartD(MdStartD), .MdReadD(MdReadD), .ImemReadyF(ImemReadyF),
    .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE), .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD),
    .MdBusy(s_MdBusy), .StallCount(s_StallCount)
  );

  typedef struct {
    string       name;
    logic [10:0] o;
    logic [31:0] c;
    logic [2:0]  cs;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  task automatic clr_in();
    RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
    WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0; BranchD = 1'b0; PCSrcD = 1'b0;
    MdStartD = 1'b0; MdReadD = 1'b0; ImemReadyF = 1'b1;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    clr_in();
  endtask

  // Order: StallF StallD FlushD FlushE ForwardAE ForwardBE ForwardAD ForwardBD MdBusy
  task automatic push_exp(input string nm, input logic sf, input logic sd, input logic fd,
                          input logic fe, input logic [1:0] fae, input logic [1:0] fbe,
                          input logic fad, input logic fbd, input logic busy);
    exp_t e;
    e.name = nm;
    e.o    = {sf, sd, fd, fe, fae, fbe, fad, fbd, busy};
    e.c    = 32'(exp_cnt);
    e.cs   = (exp_cnt > 7) ? 3'd7 : 3'(exp_cnt);
    q.push_back(e);
    if (sd) exp_cnt++;
  endtask

  // Monitor: compare against the oldest expectation on every falling edge
  initial begin
    exp_t e;
    logic [10:0] act;
    forever begin
      @(negedge CLK);
      if (q.size() != 0) begin
        e   = q.pop_front();
        act = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD, MdBusy};
        checks++;
        if (act !== e.o) begin
          errors++;
          $display("FAIL %s outputs: got %b expected %b", e.name, act, e.o);
        end
        checks++;
        if (StallCount !== e.c) begin
          errors++;
          $display("FAIL %s StallCount: got %0d expected %0d", e.name, StallCount, e.c);
        end
        checks++;
        if (s_StallCount !== e.cs) begin
          errors++;
          $display("FAIL %s StallCount3: got %0d expected %0d", e.name, s_StallCount, e.cs);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clr_in();
    cyc(); push_exp("reset", 0,0,0,0, 2'b00,2'b00, 0,0,0);
    cyc(); rst_n = 1'b1;
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    push_exp("loaduse", 1,1,0,1, 2'b00,2'b00, 0,0,0);
    cyc(); push_exp("loaduse_clear", 0,0,0,0, 2'b00,2'b00, 0,0,0);
    cyc(); RegWriteM = 1'b1; WriteRegM = 5'd8; RegWriteW = 1'b1; WriteRegW = 5'd8; RsE = 5'd8;
    push_exp("fwd_m", 0,0,0,0, 2'b10,2'b00, 0,0,0);
    cyc(); RegWriteW = 1'b1; WriteRegW = 5'd8; RsE = 5'd8;
    push_exp("fwd_w", 0,0,0,0, 2'b01,2'b00, 0,0,0);
    cyc(); RegWriteM = 1'b1; RegWriteW = 1'b1;
    push_exp("fwd_r0", 0,0,0,0, 2'b00,2'b00, 0,0,0);
    cyc(); RegWriteM = 1'b1; WriteRegM = 5'd9; RtE = 5'd9; RsE = 5'd9; RegWriteW = 1'b1; WriteRegW = 5'd9;
    push_exp("fwd_both", 0,0,0,0, 2'b10,2'b10, 0,0,0);
    cyc(); RegWriteM = 1'b1; WriteRegM = 5'd4; RsD = 5'd4; RtD = 5'd4;
    push_exp("fwd_d", 0,0,0,0, 2'b00,2'b00, 1,1,0);
    cyc(); BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd3; RsD = 5'd3; PCSrcD = 1'b1;
    push_exp("brstall_e", 1,1,0,1, 2'b00,2'b00, 0,0,0);
    cyc(); BranchD = 1'b1; PCSrcD = 1'b1; RsD = 5'd3;
    push_exp("redirect", 0,0,1,0, 2'b00,2'b00, 0,0,0);
    cyc(); BranchD = 1'b1; MemtoRegM = 1'b1; WriteRegM = 5'd7; RtD = 5'd7;
    push_exp("brstall_m", 1,1,0,1, 2'b00,2'b00, 0,0,0);
    cyc(); MemtoRegE = 1'b1; BranchD = 1'b1; RegWriteE = 1'b1;
    push_exp("reg0_nostall", 0,0,0,0, 2'b00,2'b00, 0,0,0);
    cyc(); MdStartD = 1'b1;
    push_exp("md_start", 0,0,0,0, 2'b00,2'b00, 0,0,0);
    cyc(); push_exp("md_busy4", 0,0,0,0, 2'b00,2'b00, 0,0,1);
    cyc(); MdReadD = 1'b1; push_exp("md_read3", 1,1,0,1, 2'b00,2'b00, 0,0,1);
    cyc(); MdReadD = 1'b1; push_exp("md_read2", 1,1,0,1, 2'b00,2'b00, 0,0,1);
    cyc(); MdReadD = 1'b1; push_exp("md_read1", 1,1,0,1, 2'b00,2'b00, 0,0,1);
    cyc(); MdReadD = 1'b1; push_exp("md_read0", 0,0,0,0, 2'b00,2'b00, 0,0,0);
    cyc(); MdStartD = 1'b1; push_exp("md_start2", 0,0,0,0, 2'b00,2'b00, 0,0,0);
    cyc(); MdStartD = 1'b1; push_exp("md_restart", 1,1,0,1, 2'b00,2'b00, 0,0,1);
    cyc(); push_exp("md_busy3", 0,0,0,0, 2'b00,2'b00, 0,0,1);
    cyc(); push_exp("md_busy2", 0,0,0,0, 2'b00,2'b00, 0,0,1);
    cyc(); push_exp("md_busy1", 0,0,0,0, 2'b00,2'b00, 0,0,1);
    cyc(); push_exp("md_idle", 0,0,0,0, 2'b00,2'b00, 0,0,0);
    cyc(); ImemReadyF = 1'b0; push_exp("imiss1", 1,0,1,0, 2'b00,2'b00, 0,0,0);
    cyc(); ImemReadyF = 1'b0; MemtoRegE = 1'b1; RtE = 5'd6; RtD = 5'd6;
    push_exp("imiss_lw", 1,1,0,1, 2'b00,2'b00, 0,0,0);
    cyc(); ImemReadyF = 1'b0; push_exp("imiss3", 1,0,1,0, 2'b00,2'b00, 0,0,0);
    cyc(); ImemReadyF = 1'b0; PCSrcD = 1'b1; push_exp("imiss_redir", 1,0,1,0, 2'b00,2'b00, 0,0,0);
    cyc(); push_exp("imem_ok", 0,0,0,0, 2'b00,2'b00, 0,0,0);
    cyc(); MdStartD = 1'b1; push_exp("md_start3", 0,0,0,0, 2'b00,2'b00, 0,0,0);
    cyc(); ImemReadyF = 1'b0; push_exp("busy_imiss", 1,0,1,0, 2'b00,2'b00, 0,0,1);
    cyc(); rst_n = 1'b0; exp_cnt = 0;
    push_exp("async_reset", 0,0,0,0, 2'b00,2'b00, 0,0,0);
    cyc(); rst_n = 1'b1; push_exp("post_reset", 0,0,0,0, 2'b00,2'b00, 0,0,0);
    cyc(); MdReadD = 1'b1; push_exp("post_reset_read", 0,0,0,0, 2'b00,2'b00, 0,0,0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge CLK);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
